// File: rtl/uart_cmd_parser_if.sv
// FIFO-side handshake bundle for uart_cmd_parser: RX FIFO pop path and TX FIFO push path.
// master is the parser, slave is the UART FIFO wrapper.
interface uart_cmd_parser_if;
  logic       rx_fifo_empty;
  logic [7:0] rx_fifo_data_out;
  logic       rx_fifo_read_en;
  logic       tx_fifo_full;
  logic [7:0] tx_fifo_data_in;
  logic       tx_fifo_write_en;

  modport master (
    input  rx_fifo_empty,
    input  rx_fifo_data_out,
    output rx_fifo_read_en,
    input  tx_fifo_full,
    output tx_fifo_data_in,
    output tx_fifo_write_en
  );

  modport slave (
    output rx_fifo_empty,
    output rx_fifo_data_out,
    input  rx_fifo_read_en,
    output tx_fifo_full,
    input  tx_fifo_data_in,
    input  tx_fifo_write_en
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Collects fixed-length frames from the UART RX FIFO, matches them against a command table
// and pushes an "OKn\r\n" / "ERR\r\n" acknowledgement into the TX FIFO.
module uart_cmd_parser #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int CMD_LENGTH      = 4,
  parameter int NUM_CMDS        = 4,
  parameter int TIMEOUT_MS      = 10
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_CMDS*CMD_LENGTH*8-1:0] cmd_table,
  uart_cmd_parser_if.master                fifo,
  output logic                             cmd_valid,
  output logic [3:0]                       cmd_id,
  output logic                             busy,
  output logic [7:0]                       err_count,
  output logic [7:0]                       timeout_count
);

  localparam int FRAME_W = CMD_LENGTH * 8;
  localparam int TO_TERM = TIMEOUT_MS * (CLOCK_FREQUENCY / 1000) - 1;
  localparam int TO_W    = (TO_TERM > 1) ? $clog2(TO_TERM + 1) : 1;
  localparam int IDX_W   = $clog2(CMD_LENGTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CMD_LENGTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_TERM);

  typedef enum logic [1:0] {RECV, POP, MATCH, RESP} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    index_q;
  logic [FRAME_W-1:0]  frame_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [4:0][7:0]     resp_q;
  logic [2:0]          resp_ptr_q;
  logic                rd_en_q;
  logic                wr_en_q;
  logic [7:0]          tx_data_q;
  logic                cmd_valid_q;
  logic [3:0]          cmd_id_q;
  logic                busy_q;
  logic [7:0]          err_q;
  logic [7:0]          to_count_q;

  logic [NUM_CMDS-1:0] hit_vec;
  logic                match_hit_d;
  logic [3:0]          match_id_d;

  for (genvar gi = 0; gi < NUM_CMDS; gi++) begin : g_cmp
    assign hit_vec[gi] = (frame_q == cmd_table[gi*FRAME_W +: FRAME_W]);
  end

  // Scan downwards so the lowest matching entry is the one left standing.
  always_comb begin
    match_hit_d = |hit_vec;
    match_id_d  = '0;
    for (int k = NUM_CMDS - 1; k >= 0; k--) begin
      if (hit_vec[k]) match_id_d = 4'(k);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RECV;
      index_q     <= '0;
      frame_q     <= '0;
      to_cnt_q    <= '0;
      resp_ptr_q  <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      tx_data_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= '0;
      to_count_q  <= '0;
    end else begin
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      busy_q      <= (state_q != RECV);
      case (state_q)
        RECV: begin
          // An arriving byte takes priority over a timeout due in the same cycle.
          if (!fifo.rx_fifo_empty) begin
            frame_q[{index_q, 3'b000} +: 8] <= fifo.rx_fifo_data_out;
            rd_en_q  <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= POP;
          end else if (index_q != '0) begin
            if (to_cnt_q == TO_LAST) begin
              index_q  <= '0;
              to_cnt_q <= '0;
              if (to_count_q != 8'hFF) to_count_q <= to_count_q + 8'd1;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end
        POP: begin
          if (index_q == LAST_IDX) begin
            index_q <= '0;
            state_q <= MATCH;
          end else begin
            index_q <= index_q + 1'b1;
            state_q <= RECV;
          end
        end
        MATCH: begin
          if (match_hit_d) begin
            cmd_valid_q <= 1'b1;
            cmd_id_q    <= match_id_d;
            resp_q      <= {8'h0A, 8'h0D, 8'h30 + {4'h0, match_id_d}, 8'h4B, 8'h4F};
          end else begin
            resp_q      <= {8'h0A, 8'h0D, 8'h52, 8'h52, 8'h45};
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
          end
          resp_ptr_q <= '0;
          state_q    <= RESP;
        end
        RESP: begin
          if (!fifo.tx_fifo_full) begin
            tx_data_q <= resp_q[resp_ptr_q];
            wr_en_q   <= 1'b1;
            if (resp_ptr_q == 3'd4) begin
              resp_ptr_q <= '0;
              state_q    <= RECV;
            end else begin
              resp_ptr_q <= resp_ptr_q + 3'd1;
            end
          end
        end
        default: state_q <= RECV;
      endcase
    end
  end

  assign fifo.rx_fifo_read_en  = rd_en_q;
  assign fifo.tx_fifo_write_en = wr_en_q;
  assign fifo.tx_fifo_data_in  = tx_data_q;
  assign cmd_valid             = cmd_valid_q;
  assign cmd_id                = cmd_id_q;
  assign busy                  = busy_q;
  assign err_count             = err_q;
  assign timeout_count         = to_count_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: FWFT RX FIFO and TX sink modelled inline, timeout
// shortened to 20 cycles (10 cycles per ms, 2 ms).
module tb_uart_cmd_parser;
  localparam int CF  = 10000;
  localparam int CL  = 4;
  localparam int NC  = 4;
  localparam int TMS = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NC*CL*8-1:0] cmd_table;
  logic              cmd_valid;
  logic [3:0]        cmd_id;
  logic              busy;
  logic [7:0]        err_count;
  logic [7:0]        timeout_count;

  uart_cmd_parser_if fifo ();

  uart_cmd_parser #(
    .CLOCK_FREQUENCY(CF), .CMD_LENGTH(CL), .NUM_CMDS(NC), .TIMEOUT_MS(TMS)
  ) dut (
    .clock(clock), .reset(reset), .cmd_table(cmd_table), .fifo(fifo.master),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .busy(busy),
    .err_count(err_count), .timeout_count(timeout_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int pops, last_pop_cyc, valid_cnt, last_valid_cyc, first_wr_cyc, last_wr_cyc;
  int dbl_rd, wr_full, underflow, busy_fall_cyc;
  logic prev_rd = 1'b0;
  logic prev_busy = 1'b0;

  function automatic logic [31:0] w4(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [39:0] ok_resp(input int k);
    logic [7:0] d;
    d = 8'h30 + 8'(k);
    return {8'h0A, 8'h0D, d, 8'h4B, 8'h4F};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sync_rx();
    fifo.rx_fifo_empty    = (rx_q.size() == 0);
    fifo.rx_fifo_data_out = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    if (fifo.rx_fifo_read_en === 1'b1) begin
      if (prev_rd) dbl_rd++;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      else underflow++;
      pops++;
      last_pop_cyc = cyc;
    end
    prev_rd = (fifo.rx_fifo_read_en === 1'b1);
    if (fifo.tx_fifo_write_en === 1'b1) begin
      if (fifo.tx_fifo_full) wr_full++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      tx_q.push_back(fifo.tx_fifo_data_in);
    end
    if (cmd_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (prev_busy && busy === 1'b0) busy_fall_cyc = cyc;
    prev_busy = (busy === 1'b1);
    sync_rx();
  endtask

  task automatic clear_trk();
    tx_q.delete();
    pops = 0; valid_cnt = 0; first_wr_cyc = -1; last_wr_cyc = -1;
    last_pop_cyc = -1; last_valid_cyc = -1; dbl_rd = 0; wr_full = 0;
    underflow = 0; busy_fall_cyc = -1;
  endtask

  task automatic push4(input logic [7:0] a, b, c, d);
    rx_q.push_back(a); rx_q.push_back(b); rx_q.push_back(c); rx_q.push_back(d);
    sync_rx();
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (tx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, tx_q.size(), n);
  endtask

  task automatic check_resp(input string tag, input int base, input logic [39:0] exp);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] obs;
      obs = (tx_q.size() > base + i) ? {24'h0, tx_q[base + i]} : 32'hDEAD;
      check($sformatf("%s_b%0d", tag, i), obs, {24'h0, exp[i*8 +: 8]});
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},   fifo.rx_fifo_read_en, 0);
    check({tag, "_wr_en"},   fifo.tx_fifo_write_en, 0);
    check({tag, "_tx_data"}, fifo.tx_fifo_data_in, 0);
    check({tag, "_valid"},   cmd_valid, 0);
    check({tag, "_id"},      cmd_id, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_err"},     err_count, 0);
    check({tag, "_tmo"},     timeout_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    fifo.rx_fifo_empty    = 1'b1;
    fifo.rx_fifo_data_out = 8'h00;
    fifo.tx_fifo_full     = 1'b0;
    cmd_table = {w4("S","P","I","0"), w4("L","E","D","1"), w4("L","E","D","0"), w4("T","E","S","T")};
    clear_trk();

    // Reset state
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b0;
    tick();

    // Single hit: TEST -> OK0, with latency and burst timing
    clear_trk();
    push4(8'h54, 8'h45, 8'h53, 8'h54);
    wait_tx(5, 200, "t1_count");
    repeat (3) tick();
    check("t1_total", tx_q.size(), 5);
    check_resp("t1_resp", 0, ok_resp(0));
    check("t1_valid_cnt", valid_cnt, 1);
    check("t1_id", cmd_id, 0);
    check("t1_err", err_count, 0);
    check("t1_pops", pops, 4);
    check("t1_valid_lat", last_valid_cyc - last_pop_cyc, 2);
    check("t1_wr_lat", first_wr_cyc - last_pop_cyc, 3);
    check("t1_burst", last_wr_cyc - first_wr_cyc, 4);
    check("t1_busy_fall", busy_fall_cyc - last_wr_cyc, 1);
    check("t1_dbl_rd", dbl_rd, 0);

    // Back-to-back frames SPI0 then ABCD
    clear_trk();
    push4(8'h53, 8'h50, 8'h49, 8'h30);
    push4(8'h41, 8'h42, 8'h43, 8'h44);
    wait_tx(10, 400, "t2_count");
    repeat (3) tick();
    check("t2_total", tx_q.size(), 10);
    check_resp("t2_ok3", 0, ok_resp(3));
    check_resp("t2_err", 5, 40'h0A0D525245);
    check("t2_err_cnt", err_count, 1);
    check("t2_id_held", cmd_id, 3);
    check("t2_valid_cnt", valid_cnt, 1);
    check("t2_pops", pops, 8);
    check("t2_rx_left", rx_q.size(), 0);
    check("t2_dbl_rd", dbl_rd, 0);
    check("t2_underflow", underflow, 0);

    // Partial frame dropped by timeout, then a full frame
    clear_trk();
    rx_q.push_back(8'h54); rx_q.push_back(8'h45);
    sync_rx();
    repeat (12) tick();
    check("t3_tmo_early", timeout_count, 0);
    repeat (20) tick();
    check("t3_tmo_fired", timeout_count, 1);
    check("t3_no_tx", tx_q.size(), 0);
    check("t3_idle", busy, 0);
    push4(8'h54, 8'h45, 8'h53, 8'h54);
    wait_tx(5, 200, "t3_count");
    repeat (3) tick();
    check("t3_total", tx_q.size(), 5);
    check_resp("t3_resp", 0, ok_resp(0));
    check("t3_id", cmd_id, 0);
    check("t3_tmo_hold", timeout_count, 1);
    check("t3_err_hold", err_count, 1);

    // TX backpressure from the second response byte
    clear_trk();
    push4(8'h4C, 8'h45, 8'h44, 8'h30);
    wait_tx(1, 200, "t4_first");
    fifo.tx_fifo_full = 1'b1;
    repeat (20) tick();
    check("t4_held", tx_q.size(), 1);
    fifo.tx_fifo_full = 1'b0;
    wait_tx(5, 100, "t4_count");
    repeat (3) tick();
    check("t4_total", tx_q.size(), 5);
    check("t4_wr_full", wr_full, 0);
    check_resp("t4_resp", 0, ok_resp(1));

    // Duplicate entries: lowest index wins
    cmd_table = {w4("S","P","I","0"), w4("L","E","D","1"), w4("L","E","D","1"), w4("T","E","S","T")};
    clear_trk();
    push4(8'h4C, 8'h45, 8'h44, 8'h31);
    wait_tx(5, 200, "t5_count");
    repeat (3) tick();
    check("t5_id", cmd_id, 1);
    check_resp("t5_resp", 0, ok_resp(1));

    // Reset mid-response, then a clean frame
    cmd_table = {w4("S","P","I","0"), w4("L","E","D","1"), w4("L","E","D","0"), w4("T","E","S","T")};
    clear_trk();
    push4(8'h54, 8'h45, 8'h53, 8'h54);
    wait_tx(3, 200, "t6_three");
    reset = 1'b1;
    tick();
    check_outputs_zero("t6_rst");
    reset = 1'b0;
    clear_trk();
    repeat (4) tick();
    check("t6_abandoned", tx_q.size(), 0);
    push4(8'h54, 8'h45, 8'h53, 8'h54);
    wait_tx(5, 200, "t6_count");
    repeat (3) tick();
    check("t6_total", tx_q.size(), 5);
    check_resp("t6_resp", 0, ok_resp(0));
    check("t6_id", cmd_id, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
